// File: rtl/polygraph_pkg.sv
// Shared types and constants for the polygraph session sequencer.
package polygraph_pkg;

  localparam int SENS_W = 10;

  localparam int FLG_ALARM = 3;
  localparam int FLG_BP    = 2;
  localparam int FLG_BR    = 1;
  localparam int FLG_HB    = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_BP,
    LOAD_BR,
    LOAD_HB,
    SETTLE,
    CAPTURE
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that clears on request and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/polygraph_sequencer.sv
// Assembles BP/BR/HB sensor triples onto the detector, waits for settle, captures
// the flags and keeps saturating event counters plus a debounced sticky alarm.
module polygraph_sequencer
  import polygraph_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ALARM_RUN     = 3,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [SENS_W-1:0] cfg_age,
  input  logic              s_valid,
  input  logic [SENS_W-1:0] s_data,
  output logic              s_ready,
  output logic [SENS_W-1:0] det_bloodP,
  output logic [SENS_W-1:0] det_breathR,
  output logic [SENS_W-1:0] det_heartB,
  output logic [SENS_W-1:0] det_age,
  input  logic              det_alarm,
  input  logic              det_BP,
  input  logic              det_BR,
  input  logic              det_HB,
  output logic              capt_valid,
  output logic [3:0]        capt_flags,
  output logic [CNT_W-1:0]  bp_cnt,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  hb_cnt,
  output logic [CNT_W-1:0]  alarm_cnt,
  output logic [CNT_W-1:0]  triple_cnt,
  output logic              confirmed_alarm,
  output logic              busy
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] RUN_MAX     = 4'(ALARM_RUN);

  seq_state_t state, state_nxt;
  logic [3:0] settle_cnt;
  logic [3:0] run_cnt;
  logic [3:0] run_nxt;
  logic       start_acc;
  logic       capture_fire;
  logic       settle_done;
  logic       accept;
  logic [3:0] flags;

  function automatic logic [3:0] run_step(input logic [3:0] run, input logic alarm);
    if (!alarm)
      return 4'd0;
    return (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
  endfunction

  assign start_acc    = (state == IDLE) && start && !stop;
  assign capture_fire = (state == CAPTURE) && !stop;
  assign settle_done  = (settle_cnt == SETTLE_LAST);
  assign accept       = s_valid && s_ready;
  assign busy         = (state != IDLE);
  assign run_nxt      = run_step(run_cnt, det_alarm);

  always_comb begin
    flags            = '0;
    flags[FLG_ALARM] = det_alarm;
    flags[FLG_BP]    = det_BP;
    flags[FLG_BR]    = det_BR;
    flags[FLG_HB]    = det_HB;
  end

  // Sequencing: state register and next-state / handshake decode
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE:    if (start_acc) state_nxt = LOAD_BP;
      LOAD_BP: begin
        s_ready = !stop;
        if (s_valid) state_nxt = LOAD_BR;
      end
      LOAD_BR: begin
        s_ready = !stop;
        if (s_valid) state_nxt = LOAD_HB;
      end
      LOAD_HB: begin
        s_ready = !stop;
        if (s_valid) state_nxt = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
      end
      SETTLE:  if (settle_done) state_nxt = CAPTURE;
      CAPTURE: state_nxt = LOAD_BP;
      default: state_nxt = IDLE;
    endcase
    if (stop && state != IDLE)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || state != SETTLE)
      settle_cnt <= '0;
    else if (!settle_done)
      settle_cnt <= settle_cnt + 4'd1;
  end

  // Detector drive registers, loaded one word per handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      det_bloodP  <= '0;
      det_breathR <= '0;
      det_heartB  <= '0;
      det_age     <= '0;
    end else begin
      if (start_acc)
        det_age <= cfg_age;
      if (accept) begin
        case (state)
          LOAD_BP: det_bloodP  <= s_data;
          LOAD_BR: det_breathR <= s_data;
          LOAD_HB: det_heartB  <= s_data;
          default: ;
        endcase
      end
    end
  end

  // Capture: flag register, alarm run and sticky confirmation
  always_ff @(posedge clk) begin
    if (rst) begin
      capt_valid <= 1'b0;
      capt_flags <= '0;
    end else begin
      capt_valid <= capture_fire;
      if (capture_fire)
        capt_flags <= flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      run_cnt         <= '0;
      confirmed_alarm <= 1'b0;
    end else if (capture_fire) begin
      run_cnt <= run_nxt;
      if (run_nxt == RUN_MAX)
        confirmed_alarm <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_triple_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(capture_fire), .count(triple_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_bp_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(capture_fire && det_BP), .count(bp_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_br_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(capture_fire && det_BR), .count(br_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_hb_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(capture_fire && det_HB), .count(hb_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_alarm_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(capture_fire && det_alarm), .count(alarm_cnt)
  );

endmodule

// File: tb/tb_polygraph_sequencer.sv
// Randomized self-checking bench for polygraph_sequencer against a session-level model.
module tb_polygraph_sequencer;
  import polygraph_pkg::*;

  localparam int SC   = 2;
  localparam int AR   = 3;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [SENS_W-1:0] cfg_age = '0;
  logic              s_valid = 1'b0;
  logic [SENS_W-1:0] s_data = '0;
  logic              s_ready;
  logic [SENS_W-1:0] det_bloodP, det_breathR, det_heartB, det_age;
  logic              det_alarm = 1'b0, det_BP = 1'b0, det_BR = 1'b0, det_HB = 1'b0;
  logic              capt_valid;
  logic [3:0]        capt_flags;
  logic [CW-1:0]     bp_cnt, br_cnt, hb_cnt, alarm_cnt, triple_cnt;
  logic              confirmed_alarm;
  logic              busy;

  polygraph_sequencer #(.SETTLE_CYCLES(SC), .ALARM_RUN(AR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_age(cfg_age),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .det_bloodP(det_bloodP), .det_breathR(det_breathR), .det_heartB(det_heartB),
    .det_age(det_age), .det_alarm(det_alarm), .det_BP(det_BP), .det_BR(det_BR),
    .det_HB(det_HB), .capt_valid(capt_valid), .capt_flags(capt_flags),
    .bp_cnt(bp_cnt), .br_cnt(br_cnt), .hb_cnt(hb_cnt), .alarm_cnt(alarm_cnt),
    .triple_cnt(triple_cnt), .confirmed_alarm(confirmed_alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Session model: event totals (triple, BP, BR, HB, alarm), alarm run, sticky alarm
  int m_cnt [5];
  int m_run;
  bit m_conf;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 5; k++) m_cnt[k] = 0;
    m_run  = 0;
    m_conf = 1'b0;
  endtask

  task automatic model_capture(input logic [3:0] f);
    m_cnt[0]++;
    if (f[2]) m_cnt[1]++;
    if (f[1]) m_cnt[2]++;
    if (f[0]) m_cnt[3]++;
    if (f[3]) m_cnt[4]++;
    m_run = f[3] ? ((m_run + 1 > AR) ? AR : m_run + 1) : 0;
    if (m_run == AR) m_conf = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    det_alarm = f[3];
    det_BP    = f[2];
    det_BR    = f[1];
    det_HB    = f[0];
  endtask

  task automatic send_word(input logic [SENS_W-1:0] w, output bit ok);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && guard < 20) begin
      tick();
      guard++;
    end
    ok = 1'b0;
    if (s_ready) begin
      tick();
      ok = 1'b1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_capt(output int lat);
    lat = 0;
    while (!capt_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!capt_valid) lat = -1;
  endtask

  task automatic run_triple(input logic [SENS_W-1:0] bp, br, hb, input logic [3:0] f,
                            input int maxgap, output int lat);
    bit ok0, ok1, ok2;
    set_flags(f);
    repeat ($urandom_range(0, maxgap)) tick();
    send_word(bp, ok0);
    repeat ($urandom_range(0, maxgap)) tick();
    send_word(br, ok1);
    repeat ($urandom_range(0, maxgap)) tick();
    send_word(hb, ok2);
    wait_capt(lat);
    if (!(ok0 && ok1 && ok2)) lat = -1;
    if (lat >= 0) model_capture(f);
  endtask

  task automatic do_start(input logic [SENS_W-1:0] age);
    cfg_age = age;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    model_clear();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_total++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got %b exp 0", s_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (capt_valid !== 1'b0 || capt_flags !== 4'd0)
      $display("FAIL reset_capt got %b/%b exp 0/0000", capt_valid, capt_flags); else n_pass++;
    n_total++; if ({det_bloodP, det_breathR, det_heartB, det_age} !== '0)
      $display("FAIL reset_det got %0d/%0d/%0d/%0d exp 0", det_bloodP, det_breathR, det_heartB, det_age); else n_pass++;
    n_total++; if ({triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt} !== '0)
      $display("FAIL reset_counters got %h exp 0", {triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt}); else n_pass++;
    n_total++; if (confirmed_alarm !== 1'b0) $display("FAIL reset_confirmed got %b exp 0", confirmed_alarm); else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    do_start(10'd35);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else n_pass++;
    run_triple(10'd120, 10'd18, 10'd72, 4'b0000, 0, lat);
    n_total++; if (lat !== SC + 1) $display("FAIL basic_latency got %0d exp %0d", lat, SC + 1); else n_pass++;
    n_total++; if (det_age !== 10'd35) $display("FAIL basic_age got %0d exp 35", det_age); else n_pass++;
    n_total++; if ({det_bloodP, det_breathR, det_heartB} !== {10'd120, 10'd18, 10'd72})
      $display("FAIL basic_words got %0d/%0d/%0d exp 120/18/72", det_bloodP, det_breathR, det_heartB); else n_pass++;
    n_total++; if (capt_flags !== 4'b0000) $display("FAIL basic_flags got %b exp 0000", capt_flags); else n_pass++;
    n_total++; if (triple_cnt !== CW'(sat(m_cnt[0])))
      $display("FAIL basic_triple_cnt got %0d exp %0d", triple_cnt, sat(m_cnt[0])); else n_pass++;
    tick();
    n_total++; if (capt_valid !== 1'b0) $display("FAIL basic_pulse_width got %b exp 0", capt_valid); else n_pass++;
  endtask

  task automatic test_gap();
    int lat;
    bit ok;
    bit gap_bad = 1'b0;
    logic [SENS_W-1:0] bp, br, hb, hb_old;
    logic [3:0] f;
    logic [CW-1:0] act [5];
    bp = SENS_W'($urandom); br = SENS_W'($urandom); hb = SENS_W'($urandom);
    f  = 4'($urandom);
    hb_old = det_heartB;
    set_flags(f);
    send_word(bp, ok);
    send_word(br, ok);
    for (int i = 0; i < 5; i++) begin
      if (s_ready !== 1'b1 || det_heartB !== hb_old || capt_valid !== 1'b0) gap_bad = 1'b1;
      tick();
    end
    n_total++; if (gap_bad) $display("FAIL gap_hold got s_ready=%b hb=%0d exp s_ready=1 hb=%0d", s_ready, det_heartB, hb_old); else n_pass++;
    send_word(hb, ok);
    wait_capt(lat);
    if (lat >= 0) model_capture(f);
    n_total++; if (lat !== SC + 1) $display("FAIL gap_latency got %0d exp %0d", lat, SC + 1); else n_pass++;
    n_total++; if ({det_bloodP, det_breathR, det_heartB} !== {bp, br, hb})
      $display("FAIL gap_words got %0d/%0d/%0d exp %0d/%0d/%0d", det_bloodP, det_breathR, det_heartB, bp, br, hb); else n_pass++;
    n_total++; if (capt_flags !== f) $display("FAIL gap_flags got %b exp %b", capt_flags, f); else n_pass++;
    act = '{triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt};
    for (int k = 0; k < 5; k++) begin
      n_total++; if (act[k] !== CW'(sat(m_cnt[k])))
        $display("FAIL gap_counter%0d got %0d exp %0d", k, act[k], sat(m_cnt[k])); else n_pass++;
    end
  endtask

  task automatic test_alarm_run();
    int lat;
    logic [3:0] f;
    logic [CW-1:0] act [5];
    bit pattern [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_stop();
    do_start(SENS_W'($urandom));
    for (int t = 0; t < 7; t++) begin
      f = {pattern[t], 3'($urandom)};
      run_triple(SENS_W'($urandom), SENS_W'($urandom), SENS_W'($urandom), f, 2, lat);
      n_total++; if (lat !== SC + 1) $display("FAIL alarm_latency%0d got %0d exp %0d", t, lat, SC + 1); else n_pass++;
      n_total++; if (capt_flags !== f) $display("FAIL alarm_flags%0d got %b exp %b", t, capt_flags, f); else n_pass++;
      n_total++; if (confirmed_alarm !== m_conf)
        $display("FAIL alarm_confirmed%0d got %b exp %b", t, confirmed_alarm, m_conf); else n_pass++;
      act = '{triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt};
      for (int k = 0; k < 5; k++) begin
        n_total++; if (act[k] !== CW'(sat(m_cnt[k])))
          $display("FAIL alarm_counter%0d_t%0d got %0d exp %0d", k, t, act[k], sat(m_cnt[k])); else n_pass++;
      end
    end
    n_total++; if (alarm_cnt !== CW'(5)) $display("FAIL alarm_total got %0d exp 5", alarm_cnt); else n_pass++;
    n_total++; if (confirmed_alarm !== 1'b1) $display("FAIL alarm_sticky got %b exp 1", confirmed_alarm); else n_pass++;
  endtask

  task automatic test_stop();
    int lat;
    bit ok;
    bit seen = 1'b0;
    logic [SENS_W-1:0] br_old, bp_new, age;
    logic [CW-1:0] act [5];
    do_stop();
    age = SENS_W'($urandom);
    do_start(age);
    run_triple(SENS_W'($urandom), SENS_W'($urandom), SENS_W'($urandom), 4'($urandom), 1, lat);
    n_total++; if (lat !== SC + 1) $display("FAIL stop_pre_latency got %0d exp %0d", lat, SC + 1); else n_pass++;
    br_old = det_breathR;
    bp_new = SENS_W'($urandom);
    send_word(bp_new, ok);
    s_valid = 1'b1;
    s_data  = ~br_old;
    stop    = 1'b1;
    #1;
    n_total++; if (s_ready !== 1'b0) $display("FAIL stop_s_ready got %b exp 0", s_ready); else n_pass++;
    tick();
    stop    = 1'b0;
    s_valid = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL stop_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (det_breathR !== br_old) $display("FAIL stop_word_taken got %0d exp %0d", det_breathR, br_old); else n_pass++;
    n_total++; if (det_bloodP !== bp_new || det_age !== age)
      $display("FAIL stop_det_hold got %0d/%0d exp %0d/%0d", det_bloodP, det_age, bp_new, age); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (capt_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_total++; if (seen) $display("FAIL stop_no_capture got capture exp none"); else n_pass++;
    act = '{triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt};
    for (int k = 0; k < 5; k++) begin
      n_total++; if (act[k] !== CW'(sat(m_cnt[k])))
        $display("FAIL stop_counter%0d got %0d exp %0d", k, act[k], sat(m_cnt[k])); else n_pass++;
    end
    do_start(SENS_W'($urandom));
    n_total++; if ({triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt} !== '0 || confirmed_alarm !== m_conf)
      $display("FAIL stop_restart_clear got %h/%b exp 0/0", {triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt}, confirmed_alarm); else n_pass++;
  endtask

  task automatic test_saturate();
    int lat;
    logic [3:0] f;
    logic [CW-1:0] act [5];
    do_stop();
    do_start(SENS_W'($urandom));
    for (int t = 0; t < 9; t++) begin
      f = 4'($urandom) | 4'b0100;
      run_triple(SENS_W'($urandom), SENS_W'($urandom), SENS_W'($urandom), f, 2, lat);
      n_total++; if (lat !== SC + 1) $display("FAIL sat_latency%0d got %0d exp %0d", t, lat, SC + 1); else n_pass++;
      n_total++; if (confirmed_alarm !== m_conf)
        $display("FAIL sat_confirmed%0d got %b exp %b", t, confirmed_alarm, m_conf); else n_pass++;
      act = '{triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt};
      for (int k = 0; k < 5; k++) begin
        n_total++; if (act[k] !== CW'(sat(m_cnt[k])))
          $display("FAIL sat_counter%0d_t%0d got %0d exp %0d", k, t, act[k], sat(m_cnt[k])); else n_pass++;
      end
    end
    n_total++; if (bp_cnt !== CW'(CMAX) || triple_cnt !== CW'(CMAX))
      $display("FAIL sat_final got %0d/%0d exp %0d/%0d", bp_cnt, triple_cnt, CMAX, CMAX); else n_pass++;
  endtask

  task automatic test_rst_settle();
    bit ok;
    bit seen = 1'b0;
    do_stop();
    do_start(SENS_W'($urandom) | 10'd1);
    set_flags(4'b1111);
    send_word(SENS_W'($urandom) | 10'd1, ok);
    send_word(SENS_W'($urandom) | 10'd1, ok);
    send_word(SENS_W'($urandom) | 10'd1, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if ({det_bloodP, det_breathR, det_heartB, det_age} !== '0)
      $display("FAIL rst_det got %0d/%0d/%0d/%0d exp 0", det_bloodP, det_breathR, det_heartB, det_age); else n_pass++;
    n_total++; if ({triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt} !== '0 || confirmed_alarm !== 1'b0)
      $display("FAIL rst_counters got %h/%b exp 0/0", {triple_cnt, bp_cnt, br_cnt, hb_cnt, alarm_cnt}, confirmed_alarm); else n_pass++;
    n_total++; if (busy !== 1'b0 || s_ready !== 1'b0 || capt_flags !== 4'd0)
      $display("FAIL rst_ctrl got busy=%b s_ready=%b flags=%b exp 0", busy, s_ready, capt_flags); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (capt_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_total++; if (seen) $display("FAIL rst_no_capture got capture exp none"); else n_pass++;
    set_flags(4'b0000);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_gap();
    test_alarm_run();
    test_stop();
    test_saturate();
    test_rst_settle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timed out");
  end

endmodule
